pc_gen: RTL and testbench

Parametrised program-counter generator for the instruction-fetch stage, successor to the fixed 32-bit PC register. It holds the fetch address, advances it by a configurable step under a fetch-memory ready handshake and pipeline stall, and redirects on flush (exception), branch, or return-address-stack (RAS) pop. A redirect that arrives while fetch is frozen is held until fetch can advance, so it is never lost.

---
 rtl/pc_gen.sv | 143 ++++++++++++++
 tb/tb_pc_gen.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/pc_gen.sv
// Instruction-fetch program counter: sequential advance under a ready/stall handshake,
// with redirects from flush, branch or the return-address stack.
module pc_gen #(
    parameter int                ADDR_W       = 32,
    parameter logic [ADDR_W-1:0] RESET_VECTOR = '0,
    parameter int                INST_BYTES   = 4,
    parameter int                STALL_W      = 6,
    parameter int                RAS_DEPTH    = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [STALL_W-1:0] stall,
    input  logic               if_ready_i,
    input  logic               flush_i,
    input  logic [ADDR_W-1:0]  flush_pc_i,
    input  logic               branch_flag_i,
    input  logic [ADDR_W-1:0]  branch_target_address_i,
    input  logic               ras_push_i,
    input  logic [ADDR_W-1:0]  ras_push_addr_i,
    input  logic               ras_pop_i,
    output logic [ADDR_W-1:0]  pc_o,
    output logic               ce_o,
    output logic               ras_empty_o,
    output logic               ras_full_o
);

    localparam int PTR_W = $clog2(RAS_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(RAS_DEPTH);

    typedef enum logic {ST_OFF, ST_RUN} state_t;

    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic [ADDR_W-1:0]  pend_pc_q, pend_pc_d;
    logic               pend_v_q, pend_v_d;
    logic [PTR_W-1:0]   top_q, top_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [ADDR_W-1:0]  ras_mem_q [RAS_DEPTH];

    logic               ras_we;
    logic [PTR_W-1:0]   ras_waddr;
    logic               ce;
    logic               adv;
    logic               pop_ok;
    logic               live;
    logic [ADDR_W-1:0]  live_tgt;
    logic               stall_unused;

    assign stall_unused = ^stall[STALL_W-1:1];

    always_comb begin
        ce       = (state_q == ST_RUN);
        adv      = ce & ~stall[0] & if_ready_i;
        pop_ok   = ras_pop_i & (cnt_q != '0);
        live     = branch_flag_i | pop_ok;
        live_tgt = branch_flag_i ? branch_target_address_i : ras_mem_q[top_q];
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_OFF:  state_d = ST_RUN;
            ST_RUN:  state_d = ST_RUN;
            default: state_d = ST_OFF;
        endcase
    end

    // While OFF, adv and flush are gated by ce, so pc_q simply keeps RESET_VECTOR.
    always_comb begin
        pc_d      = pc_q;
        pend_v_d  = pend_v_q;
        pend_pc_d = pend_pc_q;
        if (flush_i && ce) begin
            pc_d     = flush_pc_i;
            pend_v_d = 1'b0;
        end else if (adv && live) begin
            pc_d     = live_tgt;
            pend_v_d = 1'b0;
        end else if (adv && pend_v_q) begin
            pc_d     = pend_pc_q;
            pend_v_d = 1'b0;
        end else if (adv) begin
            pc_d = pc_q + ADDR_W'(INST_BYTES);
        end else if (live) begin
            pend_v_d  = 1'b1;
            pend_pc_d = live_tgt;
        end
    end

    // Push+pop on a non-empty stack replaces the top slot in place.
    always_comb begin
        top_d     = top_q;
        cnt_d     = cnt_q;
        ras_we    = 1'b0;
        ras_waddr = top_q;
        if (flush_i && ce) begin
            cnt_d = '0;
        end else if (ras_push_i && pop_ok) begin
            ras_we = 1'b1;
        end else if (ras_push_i) begin
            top_d     = top_q + 1'b1;
            ras_waddr = top_q + 1'b1;
            ras_we    = 1'b1;
            if (cnt_q != CNT_FULL) begin
                cnt_d = cnt_q + 1'b1;
            end
        end else if (pop_ok) begin
            top_d = top_q - 1'b1;
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_OFF;
            pc_q      <= RESET_VECTOR;
            pend_v_q  <= 1'b0;
            pend_pc_q <= '0;
            top_q     <= '0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            pend_v_q  <= pend_v_d;
            pend_pc_q <= pend_pc_d;
            top_q     <= top_d;
            cnt_q     <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (ras_we) begin
            ras_mem_q[ras_waddr] <= ras_push_addr_i;
        end
    end

    assign pc_o        = pc_q;
    assign ce_o        = ce;
    assign ras_empty_o = (cnt_q == '0);
    assign ras_full_o  = (cnt_q == CNT_FULL);

endmodule

// File: tb/tb_pc_gen.sv
// Directed bench for pc_gen: a 32-bit instance for redirect/RAS behaviour and an
// 8-bit instance for address wrap-around.
module tb_pc_gen;

    logic        clk;
    logic        rst;
    logic [5:0]  stall;
    logic        if_ready;
    logic        flush;
    logic [31:0] flush_pc;
    logic        branch;
    logic [31:0] branch_tgt;
    logic        push;
    logic [31:0] push_addr;
    logic        pop;

    logic [31:0] pc;
    logic        ce;
    logic        empty;
    logic        full;
    logic [7:0]  pc8;
    logic        ce8;
    logic        empty8;
    logic        full8;

    int asserts;
    int fails;

    pc_gen #(
        .ADDR_W(32), .RESET_VECTOR(32'h100), .INST_BYTES(4), .STALL_W(6), .RAS_DEPTH(4)
    ) dut (
        .clk(clk), .rst(rst), .stall(stall), .if_ready_i(if_ready),
        .flush_i(flush), .flush_pc_i(flush_pc),
        .branch_flag_i(branch), .branch_target_address_i(branch_tgt),
        .ras_push_i(push), .ras_push_addr_i(push_addr), .ras_pop_i(pop),
        .pc_o(pc), .ce_o(ce), .ras_empty_o(empty), .ras_full_o(full)
    );

    pc_gen #(
        .ADDR_W(8), .RESET_VECTOR(8'hFC), .INST_BYTES(4), .STALL_W(6), .RAS_DEPTH(4)
    ) dut8 (
        .clk(clk), .rst(rst), .stall(stall), .if_ready_i(if_ready),
        .flush_i(flush), .flush_pc_i(flush_pc[7:0]),
        .branch_flag_i(branch), .branch_target_address_i(branch_tgt[7:0]),
        .ras_push_i(push), .ras_push_addr_i(push_addr[7:0]), .ras_pop_i(pop),
        .pc_o(pc8), .ce_o(ce8), .ras_empty_o(empty8), .ras_full_o(full8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        asserts++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        asserts    = 0;
        fails      = 0;
        rst        = 1'b1;
        stall      = '0;
        if_ready   = 1'b1;
        flush      = 1'b0;
        flush_pc   = '0;
        branch     = 1'b0;
        branch_tgt = '0;
        push       = 1'b0;
        push_addr  = '0;
        pop        = 1'b0;

        // Reset held low
        #1 rst = 1'b0;
        #1;
        chk("rst_pc", pc, 32'h100);
        chk("rst_ce", {31'b0, ce}, 32'd0);
        chk("rst_empty", {31'b0, empty}, 32'd1);
        chk("rst_full", {31'b0, full}, 32'd0);
        chk("rst_pc8", {24'b0, pc8}, 32'hFC);
        step();
        step();
        chk("rst_hold_pc", pc, 32'h100);
        chk("rst_hold_ce", {31'b0, ce}, 32'd0);
        $display("reset: pc=%h ce=%b empty=%b full=%b", pc, ce, empty, full);

        // Release: enter RUN without advancing, then sequential fetch
        rst = 1'b1;
        step();
        chk("run_ce", {31'b0, ce}, 32'd1);
        chk("run_pc0", pc, 32'h100);
        chk("run_pc8_0", {24'b0, pc8}, 32'hFC);
        chk("run_ce8", {31'b0, ce8}, 32'd1);
        step();
        chk("run_pc1", pc, 32'h104);
        chk("wrap_pc8", {24'b0, pc8}, 32'h00);
        step();
        chk("run_pc2", pc, 32'h108);
        chk("wrap_pc8_next", {24'b0, pc8}, 32'h04);
        $display("sequential: pc=%h pc8=%h", pc, pc8);

        // Branch to 0x200
        branch = 1'b1; branch_tgt = 32'h200;
        step();
        branch = 1'b0;
        chk("br_pc", pc, 32'h200);

        // Branch to 0x400 under a 3-cycle stall
        stall = 6'b000001; branch = 1'b1; branch_tgt = 32'h400;
        step();
        branch = 1'b0;
        chk("stall_hold1", pc, 32'h200);
        step();
        chk("stall_hold2", pc, 32'h200);
        step();
        chk("stall_hold3", pc, 32'h200);
        stall = '0;
        step();
        chk("stall_redir", pc, 32'h400);
        step();
        chk("stall_seq", pc, 32'h404);
        $display("branch under stall: pc=%h", pc);

        // Branch while memory not ready
        if_ready = 1'b0; branch = 1'b1; branch_tgt = 32'h600;
        step();
        branch = 1'b0;
        chk("nrdy_hold", pc, 32'h404);
        if_ready = 1'b1;
        step();
        chk("nrdy_redir", pc, 32'h600);
        $display("branch while not ready: pc=%h", pc);

        // Flush overrides stall, not-ready and branch; RAS emptied
        push = 1'b1; push_addr = 32'h70;
        step();
        push = 1'b0;
        chk("pre_flush_pc", pc, 32'h604);
        chk("pre_flush_empty", {31'b0, empty}, 32'd0);
        flush = 1'b1; flush_pc = 32'h80; branch = 1'b1; branch_tgt = 32'h400;
        stall = 6'b000001; if_ready = 1'b0;
        step();
        flush = 1'b0; branch = 1'b0; stall = '0; if_ready = 1'b1;
        chk("flush_pc", pc, 32'h80);
        chk("flush_empty", {31'b0, empty}, 32'd1);
        step();
        chk("flush_no_branch", pc, 32'h84);
        $display("flush: pc=%h empty=%b", pc, empty);

        // RAS overflow: five pushes into four entries
        push = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            push_addr = 32'(i * 16);
            step();
            if (i == 4) chk("ras_full4", {31'b0, full}, 32'd1);
        end
        push = 1'b0;
        chk("ras_full5", {31'b0, full}, 32'd1);
        pop = 1'b1;
        step();
        chk("pop1", pc, 32'h50);
        chk("pop1_full", {31'b0, full}, 32'd0);
        step();
        chk("pop2", pc, 32'h40);
        step();
        chk("pop3", pc, 32'h30);
        step();
        chk("pop4", pc, 32'h20);
        chk("pop4_empty", {31'b0, empty}, 32'd1);
        step();
        pop = 1'b0;
        chk("pop5_noredir", pc, 32'h24);
        chk("pop5_empty", {31'b0, empty}, 32'd1);
        $display("ras overflow: pc=%h empty=%b", pc, empty);

        // Simultaneous push+pop with one entry
        push = 1'b1; push_addr = 32'h10;
        step();
        push_addr = 32'h90; pop = 1'b1;
        step();
        push = 1'b0;
        chk("pp_redir", pc, 32'h10);
        chk("pp_empty", {31'b0, empty}, 32'd0);
        chk("pp_full", {31'b0, full}, 32'd0);
        step();
        pop = 1'b0;
        chk("pp_newtop", pc, 32'h90);
        chk("pp_after_empty", {31'b0, empty}, 32'd1);
        $display("push+pop: pc=%h empty=%b", pc, empty);

        // Asynchronous reset pulse mid-stall, no clock edge
        stall = 6'b000001; branch = 1'b1; branch_tgt = 32'h300;
        step();
        branch = 1'b0;
        chk("pre_arst_pc", pc, 32'h90);
        #2 rst = 1'b0;
        #1;
        chk("arst_pc", pc, 32'h100);
        chk("arst_ce", {31'b0, ce}, 32'd0);
        chk("arst_pc8", {24'b0, pc8}, 32'hFC);
        #1 rst = 1'b1;
        stall = '0;
        step();
        chk("arst_run_pc", pc, 32'h100);
        step();
        chk("arst_no_pend", pc, 32'h104);
        $display("async reset: pc=%h ce=%b", pc, ce);

        $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
        $finish;
    end

endmodule
